// File: rtl/game_state_ctrl.sv
// Game flow controller: menu, settings, countdown, play, pause and game-over sequencing.
// Every output is a register updated by the single state machine below.
module game_state_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SPEED_W     = 4,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 8,
  parameter int SPEED_DEF   = 4,
  parameter int CD_FRAMES   = 180,
  parameter int OVER_FRAMES = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_p,
  input  logic               setting_p,
  input  logic               back_p,
  input  logic               pause_p,
  input  logic               up_p,
  input  logic               down_p,
  input  logic               mode_p,
  input  logic [SCORE_W-1:0] score_p1,
  input  logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         state,
  output logic               game_active,
  output logic               clear_scores,
  output logic [7:0]         cd_remain,
  output logic [1:0]         winner,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               multi_ball
);

  // state     | meaning
  // S_MENU    | idle, waiting for start or settings
  // S_SETTING | adjust ball speed / multi-ball
  // S_COUNT   | pre-play countdown in frame ticks
  // S_PLAY    | match running, scores watched for a win
  // S_PAUSE   | match frozen, resumes without a countdown
  // S_OVER    | result shown for a fixed hold, then back to menu
  typedef enum logic [2:0] {
    S_MENU    = 3'd0,
    S_SETTING = 3'd1,
    S_COUNT   = 3'd2,
    S_PLAY    = 3'd3,
    S_PAUSE   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam int HOLD_W = $clog2(OVER_FRAMES + 1);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [SPEED_W-1:0] SPD_MIN = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] SPD_DEF = SPEED_W'(SPEED_DEF);
  localparam logic [7:0]         CD_LD   = 8'(CD_FRAMES);
  localparam logic [HOLD_W-1:0]  HOLD_LD = HOLD_W'(OVER_FRAMES);

  state_t            cur;
  logic [HOLD_W-1:0] hold;
  logic              p1_win;
  logic              p2_win;

  assign state  = cur;
  assign p1_win = (score_p1 >= WIN_S);
  assign p2_win = (score_p2 >= WIN_S);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur          <= S_MENU;
      game_active  <= 1'b0;
      clear_scores <= 1'b0;
      cd_remain    <= 8'd0;
      winner       <= 2'd0;
      ball_speed   <= SPD_DEF;
      multi_ball   <= 1'b0;
      hold         <= '0;
    end else begin
      clear_scores <= 1'b0;
      case (cur)
        S_MENU: begin
          if (start_p) begin
            cur          <= S_COUNT;
            cd_remain    <= CD_LD;
            clear_scores <= 1'b1;
            winner       <= 2'd0;
          end else if (setting_p) begin
            cur <= S_SETTING;
          end
        end
        S_SETTING: begin
          if (back_p) begin
            cur <= S_MENU;
          end else begin
            if (up_p && !down_p && ball_speed < SPD_MAX)
              ball_speed <= ball_speed + SPEED_W'(1);
            if (down_p && !up_p && ball_speed > SPD_MIN)
              ball_speed <= ball_speed - SPEED_W'(1);
            if (mode_p)
              multi_ball <= ~multi_ball;
          end
        end
        S_COUNT: begin
          if (back_p) begin
            cur       <= S_MENU;
            cd_remain <= 8'd0;
          end else if (frame_tick) begin
            if (cd_remain <= 8'd1) begin
              cur         <= S_PLAY;
              cd_remain   <= 8'd0;
              game_active <= 1'b1;
            end else begin
              cd_remain <= cd_remain - 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (back_p) begin
            cur         <= S_MENU;
            game_active <= 1'b0;
          end else if (p1_win || p2_win) begin
            cur         <= S_OVER;
            game_active <= 1'b0;
            winner      <= {p2_win, p1_win};
            hold        <= HOLD_LD;
          end else if (pause_p) begin
            cur         <= S_PAUSE;
            game_active <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (back_p) begin
            cur <= S_MENU;
          end else if (pause_p) begin
            cur         <= S_PLAY;
            game_active <= 1'b1;
          end
        end
        S_OVER: begin
          // rematch wins over an expiring hold in the same cycle
          if (back_p) begin
            cur  <= S_MENU;
            hold <= '0;
          end else if (start_p) begin
            cur          <= S_COUNT;
            cd_remain    <= CD_LD;
            clear_scores <= 1'b1;
            winner       <= 2'd0;
            hold         <= '0;
          end else if (frame_tick) begin
            if (hold <= HOLD_W'(1)) begin
              cur  <= S_MENU;
              hold <= '0;
            end else begin
              hold <= hold - HOLD_W'(1);
            end
          end
        end
        default: begin
          cur         <= S_MENU;
          game_active <= 1'b0;
          cd_remain   <= 8'd0;
          hold        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios then random pulses, all compared
// each cycle against an integer-level model of the game flow.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, start_p = 1'b0, setting_p = 1'b0, back_p = 1'b0;
  logic       pause_p = 1'b0, up_p = 1'b0, down_p = 1'b0, mode_p = 1'b0;
  logic [3:0] score_p1 = 4'd0, score_p2 = 4'd0;
  logic [2:0] state;
  logic       game_active, clear_scores, multi_ball;
  logic [7:0] cd_remain;
  logic [1:0] winner;
  logic [3:0] ball_speed;

  int n_vec = 0;
  int n_err = 0;

  // model state, plain integers
  int m_st, m_cd, m_hold, m_win, m_spd, m_mb, m_clr, m_act;

  localparam logic [7:0] P_TICK = 8'h01, P_START = 8'h02, P_SET = 8'h04, P_BACK = 8'h08;
  localparam logic [7:0] P_PAUSE = 8'h10, P_UP = 8'h20, P_DOWN = 8'h40, P_MODE = 8'h80;

  game_state_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_p(start_p),
    .setting_p(setting_p), .back_p(back_p), .pause_p(pause_p), .up_p(up_p),
    .down_p(down_p), .mode_p(mode_p), .score_p1(score_p1), .score_p2(score_p2),
    .state(state), .game_active(game_active), .clear_scores(clear_scores),
    .cd_remain(cd_remain), .winner(winner), .ball_speed(ball_speed),
    .multi_ball(multi_ball)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic enter_countdown();
    m_st = 2; m_cd = 180; m_clr = 1; m_win = 0; m_hold = 0;
  endtask

  task automatic model_step();
    bit a, b;
    m_clr = 0;
    if (!reset) begin
      m_st = 0; m_cd = 0; m_hold = 0; m_win = 0; m_spd = 4; m_mb = 0;
    end else if (m_st != 0 && back_p) begin
      m_st = 0; m_hold = 0;
    end else begin
      case (m_st)
        0: if (start_p) enter_countdown(); else if (setting_p) m_st = 1;
        1: begin
          m_spd = clamp(m_spd + int'(up_p) - int'(down_p), 1, 8);
          if (mode_p) m_mb = 1 - m_mb;
        end
        2: if (frame_tick) begin
          m_cd = m_cd - 1;
          if (m_cd == 0) m_st = 3;
        end
        3: begin
          a = (score_p1 >= 9);
          b = (score_p2 >= 9);
          if (a || b) begin
            m_st = 5; m_win = int'(a) + 2 * int'(b); m_hold = 300;
          end else if (pause_p) m_st = 4;
        end
        4: if (pause_p) m_st = 3;
        5: if (start_p) enter_countdown();
           else if (frame_tick) begin
             m_hold = m_hold - 1;
             if (m_hold == 0) m_st = 0;
           end
        default: m_st = 0;
      endcase
    end
    if (m_st != 2) m_cd = 0;
    m_act = (m_st == 3);
  endtask

  task automatic cyc(input logic [7:0] p, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {mode_p, down_p, up_p, pause_p, back_p, setting_p, start_p, frame_tick} = p;
      @(posedge clk);
      model_step();
      #1;
      chk("state", int'(state), m_st);
      chk("game_active", int'(game_active), m_act);
      chk("clear_scores", int'(clear_scores), m_clr);
      chk("cd_remain", int'(cd_remain), m_cd);
      chk("winner", int'(winner), m_win);
      chk("ball_speed", int'(ball_speed), m_spd);
      chk("multi_ball", int'(multi_ball), m_mb);
    end
    {mode_p, down_p, up_p, pause_p, back_p, setting_p, start_p, frame_tick} = 8'h00;
  endtask

  initial begin
    m_st = 0; m_cd = 0; m_hold = 0; m_win = 0; m_spd = 4; m_mb = 0; m_clr = 0; m_act = 0;
    @(negedge clk);
    reset = 1'b0;
    cyc(8'h00, 2);
    chk("rst_state", int'(state), 0);
    chk("rst_speed", int'(ball_speed), 4);
    reset = 1'b1;

    // start, full countdown into play
    cyc(P_START);
    chk("cd_load", int'(cd_remain), 180);
    chk("clr_pulse", int'(clear_scores), 1);
    cyc(P_TICK, 179);
    chk("cd_last", int'(cd_remain), 1);
    cyc(P_TICK);
    chk("play_state", int'(state), 3);
    chk("play_active", int'(game_active), 1);

    // settings saturation and retention
    cyc(P_BACK);
    cyc(P_SET);
    cyc(P_UP, 6);
    chk("spd_max", int'(ball_speed), 8);
    cyc(P_DOWN, 9);
    chk("spd_min", int'(ball_speed), 1);
    cyc(P_UP | P_DOWN);
    chk("spd_both", int'(ball_speed), 1);
    cyc(P_MODE, 2);
    chk("mb_twice", int'(multi_ball), 0);
    cyc(P_BACK);
    chk("menu_ret", int'(state), 0);
    chk("spd_kept", int'(ball_speed), 1);

    // draw, then rematch
    cyc(P_START);
    cyc(P_TICK, 180);
    score_p1 = 4'd9; score_p2 = 4'd9;
    cyc(8'h00);
    chk("draw_state", int'(state), 5);
    chk("draw_win", int'(winner), 3);
    score_p1 = 4'd0; score_p2 = 4'd0;
    cyc(P_START);
    chk("rematch_win", int'(winner), 0);
    chk("rematch_clr", int'(clear_scores), 1);

    // pause ignores ticks, resume without clear
    cyc(P_TICK, 180);
    cyc(P_PAUSE);
    chk("pause_act", int'(game_active), 0);
    cyc(P_TICK, 10);
    cyc(P_PAUSE);
    chk("resume_state", int'(state), 3);
    chk("resume_clr", int'(clear_scores), 0);

    // over hold expiry
    score_p1 = 4'd9;
    cyc(8'h00);
    score_p1 = 4'd0;
    chk("p1_win", int'(winner), 1);
    cyc(P_TICK, 299);
    chk("hold_299", int'(state), 5);
    cyc(P_TICK);
    chk("hold_exp", int'(state), 0);
    chk("win_held", int'(winner), 1);

    // start coincident with expiring tick
    cyc(P_START);
    cyc(P_TICK, 180);
    score_p2 = 4'd12;
    cyc(8'h00);
    score_p2 = 4'd0;
    chk("p2_win", int'(winner), 2);
    cyc(P_TICK, 299);
    cyc(P_TICK | P_START);
    chk("start_prio", int'(state), 2);

    // reset mid-countdown
    cyc(P_TICK, 130);
    chk("cd_50", int'(cd_remain), 50);
    reset = 1'b0;
    cyc(8'h00);
    reset = 1'b1;
    chk("rst_cd_state", int'(state), 0);
    chk("rst_cd", int'(cd_remain), 0);
    chk("rst_cd_spd", int'(ball_speed), 4);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      logic [7:0] p;
      p[0] = ($urandom_range(0, 1) == 0);
      p[1] = ($urandom_range(0, 30) == 0);
      p[2] = ($urandom_range(0, 20) == 0);
      p[3] = ($urandom_range(0, 150) == 0);
      p[4] = ($urandom_range(0, 15) == 0);
      p[5] = ($urandom_range(0, 3) == 0);
      p[6] = ($urandom_range(0, 3) == 0);
      p[7] = ($urandom_range(0, 5) == 0);
      score_p1 = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      score_p2 = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      reset = ($urandom_range(0, 800) != 0);
      cyc(p);
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameters SHALL be:
- SCORE_W, 4, score width.
- WIN_SCORE, 9, score that ends a match.
- SPEED_W, 4, ball speed width.
- SPEED_MIN, 1, lowest ball speed.
- SPEED_MAX, 8, highest ball speed.
- SPEED_DEF, 4, ball speed after reset.
- CD_FRAMES, 180, countdown length in frame ticks.
- OVER_FRAMES, 300, game-over hold in frame ticks.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- start_p  in  1  start pulse.
- setting_p  in  1  enter-settings pulse.
- back_p  in  1  return-to-menu pulse.
- pause_p  in  1  pause/resume toggle pulse.
- up_p  in  1  speed-increment pulse.
- down_p  in  1  speed-decrement pulse.
- mode_p  in  1  multi-ball toggle pulse.
- score_p1  in  SCORE_W  player 1 score.
- score_p2  in  SCORE_W  player 2 score.
- state  out  3  current state.
- game_active  out  1  high only in PLAY.
- clear_scores  out  1  one-cycle pulse that clears the score counters.
- cd_remain  out  8  countdown frames remaining.
- winner  out  2  match result: 0 none, 1 P1, 2 P2, 3 draw.
- ball_speed  out  SPEED_W  selected ball speed.
- multi_ball  out  1  multi-ball mode enable.

Function
REQ-003 All pulse inputs SHALL be single-cycle, clk-synchronous, and sampled only at posedge clk.
REQ-004 All outputs SHALL be registered.
REQ-005 State encoding SHALL be MENU=0, SETTINGS=1, COUNTDOWN=2, PLAY=3, PAUSE=4, OVER=5; codes 6 and 7 SHALL go to MENU on the next cycle.
REQ-006 In every state except MENU, back_p SHALL have highest priority and move to MENU next cycle, aborting any counter.
REQ-007 MENU:
- start_p moves to COUNTDOWN.
- setting_p alone moves to SETTINGS.
- start_p and setting_p together move to COUNTDOWN.
REQ-008 SETTINGS:
- up_p increments ball_speed, saturating at SPEED_MAX.
- down_p decrements ball_speed, saturating at SPEED_MIN.
- up_p and down_p in the same cycle leave ball_speed unchanged.
- mode_p toggles multi_ball.
REQ-009 ball_speed and multi_ball SHALL be held constant outside SETTINGS and SHALL be retained across MENU visits.
REQ-010 Entry to COUNTDOWN SHALL load cd_remain with CD_FRAMES in the transition cycle.
REQ-011 In COUNTDOWN, each frame_tick SHALL decrement cd_remain; a frame_tick with cd_remain==1 SHALL set cd_remain to 0 and move to PLAY.
REQ-012 cd_remain SHALL be 0 in all states except COUNTDOWN.
REQ-013 clear_scores SHALL pulse high for exactly the transition cycle into COUNTDOWN from MENU or OVER, and SHALL NOT pulse on PAUSE->PLAY.
REQ-014 Entry to COUNTDOWN SHALL clear winner to 0.
REQ-015 PLAY:
- Evaluated in priority order: back_p, then the win check, then pause_p.
- Win check: score_p1>=WIN_SCORE or score_p2>=WIN_SCORE moves to OVER.
- On that move winner latches 1 (P1 only), 2 (P2 only) or 3 (both in the same cycle).
- pause_p moves to PAUSE.
REQ-016 PAUSE: pause_p SHALL return directly to PLAY with no countdown; frame_tick SHALL be ignored.
REQ-017 OVER:
- An internal hold counter loads OVER_FRAMES on entry and decrements per frame_tick.
- The frame_tick at count 1 moves to MENU.
- start_p moves to COUNTDOWN (rematch) and takes priority over expiry in the same cycle.
- winner is held until the next COUNTDOWN entry.
REQ-018 game_active SHALL equal (state==PLAY) and SHALL be updated in the same register cycle as state.
REQ-019 Pulse inputs not listed for the current state SHALL be ignored.

Reset
REQ-020 While reset==0 at posedge clk, outputs SHALL take these values:
- state=MENU, game_active=0, clear_scores=0.
- cd_remain=0, winner=0.
- ball_speed=SPEED_DEF, multi_ball=0.
- The internal hold counter SHALL also clear to 0.
REQ-021 Reset SHALL override all inputs in any state, including mid-countdown and mid-OVER hold.

Verification
REQ-022 Defaults; reset low 2 cycles, then start_p -> next cycle state=2, cd_remain=180, clear_scores=1 for 1 cycle; 180 frame_ticks -> state=3, game_active=1.
REQ-023 SETTINGS saturation:
- 6 up_p -> ball_speed=8.
- 9 down_p -> ball_speed=1.
- up_p with down_p in one cycle -> unchanged.
- mode_p twice -> multi_ball=0.
- back_p -> state=0 with settings retained.
REQ-024 In PLAY, score_p1=9 and score_p2=9 in the same cycle -> state=5, winner=3; start_p -> state=2, winner=0, clear_scores pulse.
REQ-025 In PLAY, pause_p -> state=4, game_active=0; 10 frame_ticks -> no change; pause_p -> state=3 with no clear_scores.
REQ-026 OVER hold: 300 frame_ticks -> state=0; in a separate run, start_p coincident with the expiring tick -> state=2.
REQ-027 reset low mid-COUNTDOWN with cd_remain=50 -> state=0, cd_remain=0, ball_speed=4.
